// File: rtl/cpu_ctrl_if.sv
// Control bus between cpu_ctrl and the single-cycle MIPS datapath.
// The slave modport is the controller side; master is the datapath side.
interface cpu_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             run;
  logic             step;
  logic             DMRST;
  logic             RFRST;
  logic             PCRRST;
  logic             DMWE;
  logic             RFWE;
  logic [3:0]       ALU_sel;
  logic             M_to_RF_sel;
  logic             ALU_in_sel1;
  logic             ALU_in_sel2;
  logic             PC_sel;
  logic             RFD_sel;
  logic             jump;
  logic             pc_en;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] retired;

  modport slave (
    input  opcode, funct, zero, run, step,
    output DMRST, RFRST, PCRRST, DMWE, RFWE, ALU_sel, M_to_RF_sel,
           ALU_in_sel1, ALU_in_sel2, PC_sel, RFD_sel, jump, pc_en,
           halted, err, retired
  );

  modport master (
    output opcode, funct, zero, run, step,
    input  DMRST, RFRST, PCRRST, DMWE, RFWE, ALU_sel, M_to_RF_sel,
           ALU_in_sel1, ALU_in_sel2, PC_sel, RFD_sel, jump, pc_en,
           halted, err, retired
  );
endinterface

// File: rtl/cpu_ctrl.sv
// Sequencing control for the single-cycle MIPS datapath: instruction decode,
// datapath reset sequencing and run/pause/step/halt execution control.
module cpu_ctrl #(
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 32
) (
  input  logic       CLK,
  input  logic       RST,
  cpu_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {RSTSEQ, IDLE, RUN, STEP, HALT} state_t;

  localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES);
  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
                         ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_NOR = 4'b1100,
                         ALU_SLL = 4'b1000, ALU_SRL = 4'b1001;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q;
  logic             err_q;
  logic [CNT_W-1:0] ret_q;

  logic       legal, is_halt;
  logic [3:0] alu;
  logic       rfwe, dmwe, m2rf, sel1, sel2, pcsel, rfd, jmp, pcen;
  logic       exec, stop, commit, wr_ok;

  // Raw decode, independent of state; gated below.
  always_comb begin
    legal = 1'b1; is_halt = 1'b0; alu = ALU_AND;
    rfwe = 1'b0; dmwe = 1'b0; m2rf = 1'b0; sel1 = 1'b0; sel2 = 1'b0;
    pcsel = 1'b0; rfd = 1'b0; jmp = 1'b0; pcen = 1'b0;
    case (bus.opcode)
      6'h00: begin
        rfwe = 1'b1; rfd = 1'b1; pcen = 1'b1;
        case (bus.funct)
          6'h20: alu = ALU_ADD;
          6'h22: alu = ALU_SUB;
          6'h24: alu = ALU_AND;
          6'h25: alu = ALU_OR;
          6'h27: alu = ALU_NOR;
          6'h2A: alu = ALU_SLT;
          6'h00: begin alu = ALU_SLL; sel1 = 1'b1; end
          6'h02: begin alu = ALU_SRL; sel1 = 1'b1; end
          default: begin legal = 1'b0; rfwe = 1'b0; rfd = 1'b0; pcen = 1'b0; end
        endcase
      end
      6'h23: begin alu = ALU_ADD; sel2 = 1'b1; m2rf = 1'b1; rfwe = 1'b1; pcen = 1'b1; end
      6'h2B: begin alu = ALU_ADD; sel2 = 1'b1; dmwe = 1'b1; pcen = 1'b1; end
      6'h08: begin alu = ALU_ADD; sel2 = 1'b1; rfwe = 1'b1; pcen = 1'b1; end
      6'h04: begin alu = ALU_SUB; pcsel = bus.zero;  pcen = 1'b1; end
      6'h05: begin alu = ALU_SUB; pcsel = !bus.zero; pcen = 1'b1; end
      6'h02: begin jmp = 1'b1; pcen = 1'b1; end
      6'h3F: is_halt = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign exec   = (state_q == RUN) || (state_q == STEP);
  assign stop   = exec && (is_halt || !legal);
  assign commit = exec && legal && !is_halt;
  // RST in an executing cycle must keep that cycle's writes off the datapath.
  assign wr_ok  = exec && !RST;

  assign bus.DMWE        = wr_ok & dmwe;
  assign bus.RFWE        = wr_ok & rfwe;
  assign bus.pc_en       = wr_ok & pcen;
  assign bus.ALU_sel     = exec ? alu : 4'b0000;
  assign bus.M_to_RF_sel = exec & m2rf;
  assign bus.ALU_in_sel1 = exec & sel1;
  assign bus.ALU_in_sel2 = exec & sel2;
  assign bus.PC_sel      = exec & pcsel;
  assign bus.RFD_sel     = exec & rfd;
  assign bus.jump        = exec & jmp;

  assign bus.DMRST   = (state_q == RSTSEQ);
  assign bus.RFRST   = (state_q == RSTSEQ);
  assign bus.PCRRST  = (state_q == RSTSEQ);
  assign bus.halted  = (state_q == HALT);
  assign bus.err     = err_q;
  assign bus.retired = ret_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RSTSEQ: if (cnt_q == 8'd1) state_d = IDLE;
      IDLE: begin
        if (bus.run)       state_d = RUN;
        else if (bus.step) state_d = STEP;
      end
      RUN: begin
        if (stop)          state_d = HALT;
        else if (!bus.run) state_d = IDLE;
      end
      STEP:    state_d = stop ? HALT : IDLE;
      HALT:    state_d = HALT;
      default: state_d = RSTSEQ;
    endcase
    if (RST) state_d = RSTSEQ;
  end

  always_ff @(posedge CLK) begin
    state_q <= state_d;
    if (RST) begin
      cnt_q <= RST_LOAD;
      err_q <= 1'b0;
      ret_q <= '0;
    end else begin
      if (state_q == RSTSEQ) cnt_q <= cnt_q - 8'd1;
      if (exec && !legal)    err_q <= 1'b1;
      if (commit)            ret_q <= ret_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl; the bench plays the datapath side of the bus.
module tb_cpu_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cpu_ctrl_if #(.CNT_W(32)) bus ();
  cpu_ctrl #(.RST_CYCLES(4), .CNT_W(32)) dut (.CLK(clk), .RST(rst), .bus(bus));

  // {DMWE,RFWE,ALU_sel[3:0],M_to_RF_sel,ALU_in_sel1,ALU_in_sel2,PC_sel,RFD_sel,jump,pc_en}
  localparam int NV = 15;
  localparam logic [5:0]  OPS [NV] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                       6'h23, 6'h2B, 6'h04, 6'h04, 6'h05, 6'h05, 6'h02};
  localparam logic [5:0]  FNS [NV] = '{6'h00, 6'h02, 6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A,
                                       6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
  localparam logic        ZS  [NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
  localparam logic [12:0] EXP [NV] = '{
    13'b0_1_1000_0_1_0_0_1_0_1,  // sll
    13'b0_1_1001_0_1_0_0_1_0_1,  // srl
    13'b0_1_0010_0_0_0_0_1_0_1,  // add
    13'b0_1_0110_0_0_0_0_1_0_1,  // sub
    13'b0_1_0000_0_0_0_0_1_0_1,  // and
    13'b0_1_0001_0_0_0_0_1_0_1,  // or
    13'b0_1_1100_0_0_0_0_1_0_1,  // nor
    13'b0_1_0111_0_0_0_0_1_0_1,  // slt
    13'b0_1_0010_1_0_1_0_0_0_1,  // lw
    13'b1_0_0010_0_0_1_0_0_0_1,  // sw
    13'b0_0_0110_0_0_0_0_0_0_1,  // beq not taken
    13'b0_0_0110_0_0_0_1_0_0_1,  // beq taken
    13'b0_0_0110_0_0_0_1_0_0_1,  // bne taken
    13'b0_0_0110_0_0_0_0_0_0_1,  // bne not taken
    13'b0_0_0000_0_0_0_0_0_1_1   // j
  };

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    bus.run = 1'b0; bus.step = 1'b0; bus.opcode = 6'h08; bus.funct = 6'h00; bus.zero = 1'b0;
    rst = 1'b1; tick; rst = 1'b0;
    repeat (4) tick;
  endtask

  task automatic test_reset;
    bus.run = 1'b0; bus.step = 1'b0; bus.opcode = 6'h08; bus.funct = 6'h00; bus.zero = 1'b0;
    rst = 1'b1; tick; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if ({bus.DMRST, bus.RFRST, bus.PCRRST} !== 3'b111) begin
        n_fail++; $display("FAIL reset_hold cyc %0d got %b exp 111", i, {bus.DMRST, bus.RFRST, bus.PCRRST});
      end
      n_tests++;
      if ({bus.RFWE, bus.DMWE, bus.halted, bus.err} !== 4'b0000 || bus.retired !== 32'd0) begin
        n_fail++; $display("FAIL reset_state cyc %0d got we/halt/err %b ret %0d exp 0000 ret 0", i,
                           {bus.RFWE, bus.DMWE, bus.halted, bus.err}, bus.retired);
      end
      tick;
    end
    @(negedge clk);
    n_tests++;
    if ({bus.DMRST, bus.RFRST, bus.PCRRST, bus.halted} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_release got %b exp 0000", {bus.DMRST, bus.RFRST, bus.PCRRST, bus.halted});
    end
    // RST during RSTSEQ restarts the full count
    tick;
    rst = 1'b1; tick; rst = 1'b0;
    tick; tick;
    rst = 1'b1; tick; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus.DMRST !== 1'b1) begin
        n_fail++; $display("FAIL reset_reload cyc %0d got %b exp 1", i, bus.DMRST);
      end
      tick;
    end
    @(negedge clk);
    n_tests++;
    if (bus.PCRRST !== 1'b0) begin
      n_fail++; $display("FAIL reset_reload_release got %b exp 0", bus.PCRRST);
    end
  endtask

  task automatic test_program;
    do_reset;
    bus.run = 1'b1; bus.opcode = 6'h08;
    @(negedge clk);
    n_tests++;
    if (bus.pc_en !== 1'b0) begin
      n_fail++; $display("FAIL prog_idle_pc_en got %b exp 0", bus.pc_en);
    end
    tick;
    @(negedge clk);
    n_tests++;
    if ({bus.RFWE, bus.ALU_sel, bus.ALU_in_sel2, bus.pc_en, bus.DMWE} !== 8'b1_0010_1_1_0) begin
      n_fail++; $display("FAIL prog_addi got %b exp 10010110", {bus.RFWE, bus.ALU_sel, bus.ALU_in_sel2, bus.pc_en, bus.DMWE});
    end
    tick;
    @(negedge clk);
    n_tests++;
    if (bus.retired !== 32'd1) begin
      n_fail++; $display("FAIL prog_ret1 got %0d exp 1", bus.retired);
    end
    tick;
    bus.opcode = 6'h04; bus.zero = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bus.PC_sel, bus.ALU_sel, bus.RFWE, bus.pc_en} !== 7'b1_0110_0_1) begin
      n_fail++; $display("FAIL prog_beq got %b exp 1011001", {bus.PC_sel, bus.ALU_sel, bus.RFWE, bus.pc_en});
    end
    tick;
    // branch skips addi $3; next fetched is halt
    bus.opcode = 6'h3F; bus.zero = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.pc_en, bus.RFWE, bus.DMWE, bus.halted} !== 4'b0000 || bus.retired !== 32'd3) begin
      n_fail++; $display("FAIL prog_halt_cycle got %b ret %0d exp 0000 ret 3", {bus.pc_en, bus.RFWE, bus.DMWE, bus.halted}, bus.retired);
    end
    tick;
    @(negedge clk);
    n_tests++;
    if ({bus.halted, bus.err} !== 2'b10 || bus.retired !== 32'd3) begin
      n_fail++; $display("FAIL prog_halted got %b ret %0d exp 10 ret 3", {bus.halted, bus.err}, bus.retired);
    end
  endtask

  task automatic test_step;
    int pcen_cnt;
    pcen_cnt = 0;
    do_reset;
    bus.opcode = 6'h08;
    for (int k = 0; k < 3; k++) begin
      bus.step = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.pc_en !== 1'b0) begin
        n_fail++; $display("FAIL step_idle pulse %0d got %b exp 0", k, bus.pc_en);
      end
      tick;
      bus.step = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (bus.pc_en === 1'b1) pcen_cnt++;
        tick;
      end
    end
    n_tests++;
    if (pcen_cnt !== 3 || bus.retired !== 32'd3) begin
      n_fail++; $display("FAIL step_count got pc_en %0d ret %0d exp 3 ret 3", pcen_cnt, bus.retired);
    end
  endtask

  task automatic test_decode;
    logic [12:0] obs;
    do_reset;
    bus.run = 1'b1;
    tick;
    for (int i = 0; i < NV; i++) begin
      bus.opcode = OPS[i]; bus.funct = FNS[i]; bus.zero = ZS[i];
      @(negedge clk);
      obs = {bus.DMWE, bus.RFWE, bus.ALU_sel, bus.M_to_RF_sel, bus.ALU_in_sel1,
             bus.ALU_in_sel2, bus.PC_sel, bus.RFD_sel, bus.jump, bus.pc_en};
      n_tests++;
      if (obs !== EXP[i]) begin
        n_fail++; $display("FAIL decode op %h fn %h z %b got %b exp %b", OPS[i], FNS[i], ZS[i], obs, EXP[i]);
      end
      tick;
    end
    @(negedge clk);
    n_tests++;
    if (bus.retired !== 32'(NV) || bus.halted !== 1'b0) begin
      n_fail++; $display("FAIL decode_retired got %0d halted %b exp %0d halted 0", bus.retired, bus.halted, NV);
    end
  endtask

  task automatic test_illegal;
    do_reset;
    bus.run = 1'b1;
    tick;
    bus.opcode = 6'h3E;
    @(negedge clk);
    n_tests++;
    if ({bus.pc_en, bus.RFWE, bus.DMWE} !== 3'b000) begin
      n_fail++; $display("FAIL illegal_writes got %b exp 000", {bus.pc_en, bus.RFWE, bus.DMWE});
    end
    tick;
    bus.opcode = 6'h08;
    for (int i = 0; i < 6; i++) begin
      bus.run = (i % 2 == 1); bus.step = (i % 2 == 0);
      @(negedge clk);
      n_tests++;
      if ({bus.halted, bus.err, bus.pc_en, bus.RFWE} !== 4'b1100) begin
        n_fail++; $display("FAIL illegal_stuck cyc %0d got %b exp 1100", i, {bus.halted, bus.err, bus.pc_en, bus.RFWE});
      end
      tick;
    end
    n_tests++;
    if (bus.retired !== 32'd0) begin
      n_fail++; $display("FAIL illegal_retired got %0d exp 0", bus.retired);
    end
    do_reset;
    @(negedge clk);
    n_tests++;
    if ({bus.halted, bus.err} !== 2'b00) begin
      n_fail++; $display("FAIL illegal_cleared got %b exp 00", {bus.halted, bus.err});
    end
    // unlisted R-type funct
    bus.run = 1'b1;
    tick;
    bus.opcode = 6'h00; bus.funct = 6'h01;
    @(negedge clk);
    n_tests++;
    if ({bus.RFWE, bus.RFD_sel, bus.pc_en} !== 3'b000) begin
      n_fail++; $display("FAIL illegal_funct got %b exp 000", {bus.RFWE, bus.RFD_sel, bus.pc_en});
    end
    tick;
    @(negedge clk);
    n_tests++;
    if ({bus.halted, bus.err} !== 2'b11) begin
      n_fail++; $display("FAIL illegal_funct_err got %b exp 11", {bus.halted, bus.err});
    end
  endtask

  task automatic test_rst_mid;
    do_reset;
    bus.run = 1'b1;
    tick;
    bus.opcode = 6'h2B;
    @(negedge clk);
    n_tests++;
    if (bus.DMWE !== 1'b1) begin
      n_fail++; $display("FAIL mid_sw got %b exp 1", bus.DMWE);
    end
    tick;
    bus.opcode = 6'h23; rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bus.RFWE, bus.pc_en} !== 2'b00 || bus.retired !== 32'd1) begin
      n_fail++; $display("FAIL mid_lw_suppress got %b ret %0d exp 00 ret 1", {bus.RFWE, bus.pc_en}, bus.retired);
    end
    tick;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.DMRST, bus.RFRST, bus.PCRRST, bus.pc_en} !== 4'b1110 || bus.retired !== 32'd0) begin
      n_fail++; $display("FAIL mid_reset got %b ret %0d exp 1110 ret 0", {bus.DMRST, bus.RFRST, bus.PCRRST, bus.pc_en}, bus.retired);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    test_reset;
    test_program;
    test_step;
    test_decode;
    test_illegal;
    test_rst_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Sequencing control unit for the single-cycle MIPS datapath. Decodes `opcode`/`funct`/`zero` into the datapath control lines, and owns the datapath reset sequence. Adds run/pause/single-step/halt execution control through a PC-enable. Sits beside `datapath`; the PCR gains an enable input driven by `pc_en`.

## Interface
- `RST_CYCLES`, 4: cycles `DMRST`/`RFRST`/`PCRRST` are held after `RST` deasserts; legal range 1..255.
- `CNT_W`, 32: width of the retired-instruction counter.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `opcode` in 6: from datapath `opcode_out`.
- `funct` in 6: from datapath `funct_out`.
- `zero` in 1: from datapath `zero_out`.
- `run` in 1: level; 1 = free-run, 0 = pause.
- `step` in 1: single-cycle pulse; requests one instruction while paused.
- `DMRST`, `RFRST`, `PCRRST` out 1 each: registered datapath resets.
- `DMWE`, `RFWE` out 1 each: memory and register-file write enables.
- `ALU_sel` out 4: ALU operation.
- `M_to_RF_sel`, `ALU_in_sel1`, `ALU_in_sel2`, `PC_sel`, `RFD_sel`, `jump` out 1 each: datapath mux selects.
- `pc_en` out 1: PC register load enable.
- `halted` out 1: registered; 1 in HALT.
- `err` out 1: registered, sticky; 1 when halted by an illegal instruction.
- `retired` out CNT_W: registered count of retired instructions.

## Operation
- States: RSTSEQ, IDLE, RUN, STEP, HALT.
- RSTSEQ: entered on `RST`. All three resets stay 1 until a down-counter loaded with RST_CYCLES reaches 0, then the FSM goes to IDLE.
- IDLE transitions: `run`=1 goes to RUN; else `step`=1 goes to STEP. `run` has priority.
- RUN: executes one instruction per cycle. `run`=0 goes to IDLE.
- STEP: executes exactly one instruction, then goes to IDLE regardless of `run`/`step`.
- HALT: exits only via `RST`.
- In RSTSEQ, IDLE and HALT, all of these are 0: `DMWE`, `RFWE`, `pc_en`, `jump`, `PC_sel`.
- ALU_sel encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
  - 0111 SLT, 1100 NOR.
  - 1000 SLL, 1001 SRL; each shifts in2 by in1.
- Decode in RUN/STEP. Any field not listed is 0.
- R-type, `opcode`=0x00: `RFWE`=1, `RFD_sel`=1, `pc_en`=1.
  - `funct` mapping: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT.
  - 0x00 SLL and 0x02 SRL additionally set `ALU_in_sel1`=1.
- lw 0x23: ADD, `ALU_in_sel2`=1, `M_to_RF_sel`=1, `RFWE`=1, `pc_en`=1.
- sw 0x2B: ADD, `ALU_in_sel2`=1, `DMWE`=1, `pc_en`=1.
- addi 0x08: ADD, `ALU_in_sel2`=1, `RFWE`=1, `pc_en`=1.
- beq 0x04: SUB, `PC_sel`=`zero`, `pc_en`=1.
- bne 0x05: SUB, `PC_sel`=!`zero`, `pc_en`=1.
- j 0x02: `jump`=1, `pc_en`=1.
- halt 0x3F: no writes, `pc_en`=0. Next state HALT; not counted.
- Illegal encoding (any other opcode, or R-type with an unlisted funct): same as halt, plus `err` set.
- `retired` increments on each RUN/STEP cycle executing a legal non-halt instruction. It wraps modulo 2^CNT_W.

## Timing
- Decode outputs (`DMWE`, `RFWE`, `ALU_sel`, selects, `jump`, `pc_en`) are combinational from state, `opcode`, `funct` and `zero`. They are valid within the same cycle, as the single-cycle datapath requires.
- Register write and PC update occur on the edge that ends the executing cycle.
- State, resets, `halted`, `err` and `retired` are registered.
- Reset values, the cycle after `RST` is sampled: state RSTSEQ; `DMRST`=`RFRST`=`PCRRST`=1; `halted`=0; `err`=0; `retired`=0.
- Reset release: resets deassert RST_CYCLES cycles after the first cycle with `RST`=0. IDLE is entered on that same edge.
- First instruction latency: `run` sampled 1 in IDLE puts RUN in the next cycle, which executes the instruction at PC 0.
- Pause: `run` low in RUN. The instruction in that cycle still executes; the next cycle is IDLE.
- `step` is ignored outside IDLE, and while `run`=1 in IDLE.
- `RST` mid-instruction suppresses that cycle's writes: state is forced to RSTSEQ on that edge, and the reset outputs win over everything else.
- `RST` during RSTSEQ reloads the counter.

## Test plan
- Release `RST` with RST_CYCLES=4 -> resets stay 1 for 4 cycles, then 0; `halted`=0, `retired`=0, no `RFWE`/`DMWE` pulses.
- `run`=1; program addi $1,$0,5; addi $2,$0,5; beq $1,$2,+1; addi $3,$0,9; halt -> `PC_sel`=1 on beq, $3 never written, `halted`=1, `retired`=3.
- Paused; pulse `step` 3 times, 5 cycles apart -> exactly 3 cycles with `pc_en`=1, `retired`=3, state returns to IDLE after each.
- R-type sll $4,$1,2 with $1=5 -> `ALU_sel`=1000, `ALU_in_sel1`=1, `RFD_sel`=1, $4=20.
- Opcode 0x3E in RUN -> no writes, `pc_en`=0, `halted`=1, `err`=1; `run`/`step` toggles are ignored until `RST`.
- sw then `RST` asserted in the lw cycle -> lw not written back, resets reasserted, `retired`=0.
